nco_voice_scheduler: RTL and testbench
======================================

Name: nco_voice_scheduler

Overview:
- Time-multiplexes one shared NCO waveform/interpolation datapath across NUM_VOICES polyphonic voices.
- Owns the per-voice phase accumulators, increments and key bindings, and allocates voices from key events supplied by tone_frequency_calculator.
- On each 48 kHz sample tick it sweeps all active voices through the datapath, sums the returned samples and presents one saturated mix sample to i2s_transmitter.

Parameters:
- NUM_VOICES, 8, voice count; power of two, 2..16
- KEY_W, 7, key identifier width
- PHASE_W, 32, phase accumulator / increment width
- SAMPLE_W, 16, signed waveform and mix sample width

Ports:
- master_clk  in  1  system clock; sole clock
- rst  in  1  asynchronous active-high reset
- sample_tick  in  1  one-cycle pulse at 48 kHz
- key_on  in  1  key press event, one-cycle pulse
- key_off  in  1  key release event, one-cycle pulse
- key_id  in  KEY_W  key for key_on/key_off
- key_increment  in  PHASE_W  accumulator increment for key_on
- phase_valid  out  1  phase request to datapath
- phase_out  out  PHASE_W  phase of current voice
- phase_ready  in  1  datapath accepts phase
- wave_valid  in  1  datapath returns sample
- wave_sample  in  SAMPLE_W  signed sample for the last accepted phase
- mix_valid  out  1  one-cycle pulse, mix_out is new
- mix_out  out  SAMPLE_W  saturated signed voice sum
- all_muted  out  1  no voice active
- busy  out  1  sweep in progress
- overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: all voices inactive; phases, increments and key bindings 0; steal_ptr 0; FSM IDLE; phase_valid 0, phase_out 0, mix_valid 0, mix_out 0, busy 0, overrun 0, all_muted 1.
- Reset asserted mid-sweep aborts the sweep immediately. No mix_valid is produced.
- Voice table updates are applied in every cycle, independent of the FSM:
  - key_off: every active voice bound to key_id goes inactive.
  - key_on, key_id already held: retrigger that voice. Phase resets to 0 and the increment is replaced.
  - key_on, key not held: allocate the lowest-index free voice. If none is free, steal the voice at steal_ptr.
  - Any allocation or steal sets that voice active with phase 0, binding key_id and increment key_increment. steal_ptr advances modulo NUM_VOICES on every fresh allocation.
  - key_on and key_off in the same cycle: key_off is applied first, then key_on. With the same key_id, the result is an active voice with phase 0.
  - A key_on write to a voice wins over the sweep phase write-back in the same cycle.
- all_muted is registered, equal to NOR of the active flags. It updates one cycle after the table changes.
- FSM states: IDLE, CHECK, ISSUE, WAIT, DONE.
  - IDLE: on sample_tick, clear the accumulator, set vidx to 0 and go to CHECK. busy is 1 in every state except IDLE.
  - CHECK: if voice[vidx] is inactive, skip to the next vidx, or to DONE after the last voice. Otherwise go to ISSUE.
  - ISSUE: phase_valid=1, phase_out=phase[vidx]. On phase_ready, write back phase[vidx] += increment[vidx], wrapping modulo 2^PHASE_W, then go to WAIT.
  - The phase presented to the datapath is the pre-increment phase.
  - WAIT: on wave_valid, sign-extend wave_sample into a SAMPLE_W+log2(NUM_VOICES) accumulator and add it. Advance vidx, or go to DONE after the last voice. wave_valid in any other state is ignored.
  - DONE: saturate the accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Register the result to mix_out, pulse mix_valid for one cycle and return to IDLE.
- Latency: tick to mix_valid = 2 + NUM_VOICES CHECK cycles + per-active-voice handshake time.
- With zero active voices, mix_out = 0, still delivered on every tick.
- sample_tick while not in IDLE sets overrun (sticky until rst). The tick is ignored.
- A voice that key_off deactivates mid-sweep is skipped if its CHECK has not yet occurred. If the sample was already accumulated, it stays in the mix.

Decomposition:
- nco_pkg holds:
  - the sched_state_t enum
  - the NUM_VOICES, PHASE_W and SAMPLE_W defaults
  - a voice_t struct with active, key, increment and phase fields
  - the saturate function
- Sub-module nco_voice_allocator holds the voice table, free-search priority encoder, steal_ptr and key_on/key_off/retrigger logic. It exposes a read port by vidx and a phase write-back port.

Test Plan:
- Reset, then 3 ticks with no keys → three mix_valid pulses, mix_out=0, all_muted=1, phase_valid never asserted.
- key_on(id 60, inc 0x0100_0000), datapath echoes wave_sample = phase_out[31:16] → successive phases 0, 0x0100_0000, 0x0200_0000; mix_out 0x0000, 0x0100, 0x0200.
- Two voices with constant samples 0x6000 and 0x6000 → mix_out saturates to 0x7FFF. Two voices at 0xA000 → mix_out 0x8000.
- key_on for 9 distinct keys (NUM_VOICES=8) → 9th steals voice 0 (steal_ptr 0); key_off(first key) has no effect, and 8 voices stay active.
- phase_ready held low for 3000 cycles, second tick during sweep → overrun=1, tick ignored, sweep completes with a single mix_valid.
- key_on and key_off on the same key_id in one cycle → voice active, phase 0. rst pulse mid-WAIT → all outputs at reset values, no mix_valid.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared types, defaults and the mix saturation helper for the NCO voice scheduler.
package nco_pkg;
   localparam int NUM_VOICES_DEF = 8;
   localparam int KEY_W_DEF      = 7;
   localparam int PHASE_W_DEF    = 32;
   localparam int SAMPLE_W_DEF   = 16;

   typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} sched_state_t;

   typedef struct packed {
      logic                   active;
      logic [KEY_W_DEF-1:0]   key;
      logic [PHASE_W_DEF-1:0] increment;
      logic [PHASE_W_DEF-1:0] phase;
   } voice_t;

   // Clamp v into the signed range of a w-bit sample.
   function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi, lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction
endpackage

// File: rtl/nco_voice_allocator.sv
// Voice table: key binding, retrigger, lowest-free allocation and round-robin steal,
// plus a read port by voice index and a phase write-back port for the sweep.
module nco_voice_allocator
   import nco_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEF,
   localparam int VIDX_W = $clog2(NUM_VOICES)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_on,
   input  logic                   key_off,
   input  logic [KEY_W_DEF-1:0]   key_id,
   input  logic [PHASE_W_DEF-1:0] key_increment,
   input  logic [VIDX_W-1:0]      rd_idx,
   output logic                   rd_active,
   output logic [PHASE_W_DEF-1:0] rd_phase,
   output logic [PHASE_W_DEF-1:0] rd_increment,
   input  logic                   wb_en,
   input  logic [VIDX_W-1:0]      wb_idx,
   input  logic [PHASE_W_DEF-1:0] wb_phase,
   output logic [NUM_VOICES-1:0]  active
);
   voice_t [NUM_VOICES-1:0] tbl, tbl_n;
   logic [VIDX_W-1:0]       steal_ptr, steal_ptr_n;
   logic [NUM_VOICES-1:0]   live;
   logic                    held, free_found;
   logic [VIDX_W-1:0]       held_idx, free_idx, tgt;

   assign rd_active    = tbl[rd_idx].active;
   assign rd_phase     = tbl[rd_idx].phase;
   assign rd_increment = tbl[rd_idx].increment;

   always_comb begin
      tbl_n       = tbl;
      steal_ptr_n = steal_ptr;
      held        = 1'b0;
      free_found  = 1'b0;
      held_idx    = '0;
      free_idx    = '0;
      if (wb_en) tbl_n[wb_idx].phase = wb_phase;
      // key_off lands first so a same-cycle key_on sees the released voice as free
      for (int i = 0; i < NUM_VOICES; i++) begin
         live[i]   = tbl[i].active && !(key_off && tbl[i].key == key_id);
         active[i] = tbl[i].active;
         if (!live[i]) tbl_n[i].active = 1'b0;
      end
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (live[i] && tbl[i].key == key_id) begin
            held     = 1'b1;
            held_idx = VIDX_W'(i);
         end
         if (!live[i]) begin
            free_found = 1'b1;
            free_idx   = VIDX_W'(i);
         end
      end
      tgt = held ? held_idx : (free_found ? free_idx : steal_ptr);
      if (key_on) begin
         tbl_n[tgt] = '{active: 1'b1, key: key_id, increment: key_increment, phase: '0};
         if (!held) steal_ptr_n = steal_ptr + VIDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl       <= '0;
         steal_ptr <= '0;
      end else begin
         tbl       <= tbl_n;
         steal_ptr <= steal_ptr_n;
      end
   end
endmodule

// File: rtl/nco_voice_scheduler.sv
// Sweeps active voices through a shared NCO datapath on every sample tick and
// presents one saturated mix sample per tick.
module nco_voice_scheduler
   import nco_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEF,
   parameter int KEY_W      = KEY_W_DEF,
   parameter int PHASE_W    = PHASE_W_DEF,
   parameter int SAMPLE_W   = SAMPLE_W_DEF
)(
   input  logic                master_clk,
   input  logic                rst,
   input  logic                sample_tick,
   input  logic                key_on,
   input  logic                key_off,
   input  logic [KEY_W-1:0]    key_id,
   input  logic [PHASE_W-1:0]  key_increment,
   output logic                phase_valid,
   output logic [PHASE_W-1:0]  phase_out,
   input  logic                phase_ready,
   input  logic                wave_valid,
   input  logic [SAMPLE_W-1:0] wave_sample,
   output logic                mix_valid,
   output logic [SAMPLE_W-1:0] mix_out,
   output logic                all_muted,
   output logic                busy,
   output logic                overrun
);
   localparam int VIDX_W = $clog2(NUM_VOICES);
   localparam int ACC_W  = SAMPLE_W + VIDX_W;

   sched_state_t            state, state_n;
   logic [VIDX_W-1:0]       vidx;
   logic signed [ACC_W-1:0] acc;
   logic                    last, acc_clr, acc_add, vidx_inc, wb_en, mix_load;
   logic                    rd_active;
   logic [PHASE_W-1:0]      rd_phase, rd_inc;
   logic [NUM_VOICES-1:0]   active;

   nco_voice_allocator #(.NUM_VOICES(NUM_VOICES)) u_alloc (
      .clk          (master_clk),
      .rst          (rst),
      .key_on       (key_on),
      .key_off      (key_off),
      .key_id       (key_id),
      .key_increment(key_increment),
      .rd_idx       (vidx),
      .rd_active    (rd_active),
      .rd_phase     (rd_phase),
      .rd_increment (rd_inc),
      .wb_en        (wb_en),
      .wb_idx       (vidx),
      .wb_phase     (rd_phase + rd_inc),
      .active       (active)
   );

   assign last        = (vidx == VIDX_W'(NUM_VOICES - 1));
   assign busy        = (state != IDLE);
   assign phase_valid = (state == ISSUE);
   assign phase_out   = (state == ISSUE) ? rd_phase : '0;

   always_comb begin
      state_n  = state;
      acc_clr  = 1'b0;
      acc_add  = 1'b0;
      vidx_inc = 1'b0;
      wb_en    = 1'b0;
      mix_load = 1'b0;
      unique case (state)
         IDLE:  if (sample_tick) begin
                   acc_clr = 1'b1;
                   state_n = CHECK;
                end
         CHECK: if (rd_active) state_n = ISSUE;
                else if (last) state_n = DONE;
                else vidx_inc = 1'b1;
         ISSUE: if (phase_ready) begin
                   wb_en   = 1'b1;
                   state_n = WAIT;
                end
         WAIT:  if (wave_valid) begin
                   acc_add = 1'b1;
                   if (last) state_n = DONE;
                   else begin
                      vidx_inc = 1'b1;
                      state_n  = CHECK;
                   end
                end
         DONE:  begin
                   mix_load = 1'b1;
                   state_n  = IDLE;
                end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         vidx      <= '0;
         acc       <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
         all_muted <= 1'b1;
      end else begin
         state     <= state_n;
         mix_valid <= mix_load;
         all_muted <= ~|active;
         if (sample_tick && state != IDLE) overrun <= 1'b1;
         if (acc_clr) begin
            acc  <= '0;
            vidx <= '0;
         end
         if (vidx_inc) vidx <= vidx + VIDX_W'(1);
         if (acc_add) acc <= acc + {{VIDX_W{wave_sample[SAMPLE_W-1]}}, wave_sample};
         if (mix_load) mix_out <= SAMPLE_W'(saturate(32'(acc), SAMPLE_W));
      end
   end
endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Randomized scoreboard bench: a voice-level model predicts each mix sample,
// a monitor pops predictions whenever the DUT pulses mix_valid.
module tb_nco_voice_scheduler;
   localparam int NV = 8;

   logic        master_clk = 1'b0;
   logic        rst, sample_tick, key_on, key_off;
   logic [6:0]  key_id;
   logic [31:0] key_increment;
   logic        phase_valid;
   logic [31:0] phase_out;
   logic        phase_ready, wave_valid;
   logic [15:0] wave_sample;
   logic        mix_valid;
   logic [15:0] mix_out;
   logic        all_muted, busy, overrun;

   always #5 master_clk = ~master_clk;

   nco_voice_scheduler #(.NUM_VOICES(NV), .KEY_W(7), .PHASE_W(32), .SAMPLE_W(16)) dut (
      .master_clk   (master_clk),
      .rst          (rst),
      .sample_tick  (sample_tick),
      .key_on       (key_on),
      .key_off      (key_off),
      .key_id       (key_id),
      .key_increment(key_increment),
      .phase_valid  (phase_valid),
      .phase_out    (phase_out),
      .phase_ready  (phase_ready),
      .wave_valid   (wave_valid),
      .wave_sample  (wave_sample),
      .mix_valid    (mix_valid),
      .mix_out      (mix_out),
      .all_muted    (all_muted),
      .busy         (busy),
      .overrun      (overrun)
   );

   int          checks = 0, errors = 0;
   logic [15:0] exp_q[$];
   bit          stall = 0, wave_hold = 0;
   int          mode = 0;
   logic [15:0] cval = '0;
   int          acc_cnt = 0, pv_cnt = 0;

   typedef struct {bit act; int key; logic [31:0] inc; logic [31:0] ph;} mvoice_t;
   mvoice_t mv[NV];
   int      sptr;

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Stand-in waveform: either the top phase bits or a fixed level.
   function automatic logic [15:0] dp_sample(logic [31:0] ph);
      return (mode == 0) ? ph[31:16] : cval;
   endfunction

   function automatic void m_reset();
      for (int v = 0; v < NV; v++) mv[v] = '{1'b0, 0, 32'h0, 32'h0};
      sptr = 0;
      exp_q.delete();
   endfunction

   function automatic void m_key(bit on, bit off, int k, logic [31:0] inc);
      int tgt;
      tgt = -1;
      if (off) for (int v = 0; v < NV; v++) if (mv[v].act && mv[v].key == k) mv[v].act = 1'b0;
      if (on) begin
         for (int v = 0; v < NV; v++) if (mv[v].act && mv[v].key == k) tgt = v;
         if (tgt >= 0) begin
            mv[tgt].ph  = 32'h0;
            mv[tgt].inc = inc;
         end else begin
            for (int v = NV - 1; v >= 0; v--) if (!mv[v].act) tgt = v;
            if (tgt < 0) tgt = sptr;
            mv[tgt] = '{1'b1, k, inc, 32'h0};
            sptr = (sptr + 1) % NV;
         end
      end
   endfunction

   function automatic void m_tick();
      int sum;
      sum = 0;
      for (int v = 0; v < NV; v++) if (mv[v].act) begin
         sum += int'($signed(dp_sample(mv[v].ph)));
         mv[v].ph += mv[v].inc;
      end
      if (sum > 32767) sum = 32767;
      else if (sum < -32768) sum = -32768;
      exp_q.push_back(16'(sum));
   endfunction

   function automatic bit m_muted();
      for (int v = 0; v < NV; v++) if (mv[v].act) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_key(bit on, bit off, int k, logic [31:0] inc);
      @(negedge master_clk);
      key_on = on; key_off = off; key_id = 7'(k); key_increment = inc;
      m_key(on, off, k, inc);
      @(negedge master_clk);
      key_on = 1'b0; key_off = 1'b0;
   endtask

   task automatic do_tick(bit expect_mix);
      if (expect_mix) m_tick();
      @(negedge master_clk); sample_tick = 1'b1;
      @(negedge master_clk); sample_tick = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n;
      n = 0;
      while (busy && n < 5000) begin
         @(negedge master_clk);
         n++;
      end
      check({name, "_timeout"}, {31'h0, busy}, 32'h0);
   endtask

   task automatic check_reset(string tag);
      check({tag, "_phase_valid"}, {31'h0, phase_valid}, 32'h0);
      check({tag, "_phase_out"}, phase_out, 32'h0);
      check({tag, "_mix_valid"}, {31'h0, mix_valid}, 32'h0);
      check({tag, "_mix_out"}, {16'h0, mix_out}, 32'h0);
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
      check({tag, "_all_muted"}, {31'h0, all_muted}, 32'h1);
   endtask

   // Datapath responder: random accept delay, random return latency.
   initial begin
      logic [31:0] ph;
      phase_ready = 1'b0; wave_valid = 1'b0; wave_sample = '0;
      forever begin
         @(negedge master_clk);
         wave_valid = 1'b0; phase_ready = 1'b0;
         if (phase_valid && !stall && $urandom_range(0, 3) != 0) begin
            ph = phase_out;
            phase_ready = 1'b1;
            @(negedge master_clk);
            phase_ready = 1'b0;
            acc_cnt++;
            repeat ($urandom_range(0, 2)) @(negedge master_clk);
            while (wave_hold) @(negedge master_clk);
            wave_sample = dp_sample(ph);
            wave_valid = 1'b1;
         end
      end
   end

   // Monitor / scoreboard.
   initial forever begin
      @(negedge master_clk);
      if (phase_valid === 1'b1) pv_cnt++;
      if (mix_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mix: got %h expected no mix_valid", mix_out);
         end else check("mix_out", {16'h0, mix_out}, {16'h0, exp_q.pop_front()});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int nk, sel, k, c0, n;
      logic [31:0] inc;
      rst = 1'b1; sample_tick = 1'b0; key_on = 1'b0; key_off = 1'b0;
      key_id = '0; key_increment = '0;
      m_reset();
      repeat (3) @(negedge master_clk);
      rst = 1'b0;
      @(negedge master_clk);
      check_reset("reset");

      // Idle ticks: zero mix, no datapath traffic.
      for (int i = 0; i < 3; i++) begin
         do_tick(1'b1);
         wait_idle("idle_sweep");
      end
      @(negedge master_clk);
      check("idle_phase_valid_count", pv_cnt, 0);
      check("idle_all_muted", {31'h0, all_muted}, 32'h1);

      // Phase echo: mixes 0x0000, 0x0100, 0x0200.
      mode = 0;
      do_key(1'b1, 1'b0, 60, 32'h0100_0000);
      @(negedge master_clk);
      check("one_voice_all_muted", {31'h0, all_muted}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         do_tick(1'b1);
         wait_idle("echo_sweep");
      end
      do_key(1'b0, 1'b1, 60, 32'h0);
      @(negedge master_clk);
      check("released_all_muted", {31'h0, all_muted}, 32'h1);

      // Saturation both directions.
      mode = 1; cval = 16'h6000;
      do_key(1'b1, 1'b0, 1, 32'h10);
      do_key(1'b1, 1'b0, 2, 32'h20);
      do_tick(1'b1); wait_idle("sat_hi");
      cval = 16'hA000;
      do_tick(1'b1); wait_idle("sat_lo");

      // Steal: 9 keys into 8 voices, then release of the stolen key.
      @(negedge master_clk); rst = 1'b1; m_reset();
      @(negedge master_clk); rst = 1'b0;
      for (int i = 0; i < 9; i++) do_key(1'b1, 1'b0, 10 + i, 32'((10 + i) << 20));
      do_key(1'b0, 1'b1, 10, 32'h0);
      mode = 1; cval = 16'h0100;
      do_tick(1'b1); wait_idle("steal_const");
      mode = 0;
      do_tick(1'b1); wait_idle("steal_phase");
      do_key(1'b0, 1'b1, 11, 32'h0);
      do_key(1'b1, 1'b0, 30, 32'h0777_0000);
      do_tick(1'b1); wait_idle("steal_refill");
      do_tick(1'b1); wait_idle("steal_refill2");

      // Overrun: datapath stalls, second tick arrives mid-sweep.
      stall = 1'b1;
      do_tick(1'b1);
      repeat (3000) @(negedge master_clk);
      check("stall_busy", {31'h0, busy}, 32'h1);
      do_tick(1'b0);
      check("overrun_set", {31'h0, overrun}, 32'h1);
      stall = 1'b0;
      wait_idle("overrun_sweep");
      repeat (3) @(negedge master_clk);
      check("overrun_pending", exp_q.size(), 0);
      check("overrun_sticky", {31'h0, overrun}, 32'h1);

      // Same-cycle key_on/key_off on a held key restarts it at phase 0.
      @(negedge master_clk); rst = 1'b1; m_reset();
      @(negedge master_clk); rst = 1'b0;
      mode = 0;
      do_key(1'b1, 1'b0, 5, 32'h1000_0000);
      do_tick(1'b1); wait_idle("onoff_pre1");
      do_tick(1'b1); wait_idle("onoff_pre2");
      do_key(1'b1, 1'b1, 5, 32'h0300_0000);
      @(negedge master_clk);
      check("onoff_active", {31'h0, all_muted}, 32'h0);
      do_tick(1'b1); wait_idle("onoff_post1");
      do_tick(1'b1); wait_idle("onoff_post2");

      // Random key traffic against the model.
      for (int it = 0; it < 40; it++) begin
         nk = $urandom_range(0, 3);
         for (int j = 0; j < nk; j++) begin
            sel = $urandom_range(0, 9);
            k   = $urandom_range(0, 11);
            inc = $urandom;
            do_key(sel < 6, sel >= 5, k, inc);
         end
         mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         cval = 16'($urandom);
         @(negedge master_clk);
         check("rand_all_muted", {31'h0, all_muted}, {31'h0, m_muted()});
         do_tick(1'b1);
         wait_idle("rand_sweep");
      end

      // Reset while waiting for a sample: sweep aborted, no mix.
      mode = 0;
      do_key(1'b1, 1'b0, 100, 32'h0123_4567);
      wave_hold = 1'b1;
      c0 = acc_cnt;
      do_tick(1'b1);
      n = 0;
      while (acc_cnt == c0 && n < 500) begin
         @(negedge master_clk);
         n++;
      end
      check("rst_wait_accepted", {31'h0, acc_cnt != c0}, 32'h1);
      @(negedge master_clk);
      rst = 1'b1; m_reset();
      #1;
      check_reset("mid_wait_reset");
      @(negedge master_clk); rst = 1'b0;
      wave_hold = 1'b0;
      repeat (20) @(negedge master_clk);
      check("post_reset_busy", {31'h0, busy}, 32'h0);
      check("post_reset_all_muted", {31'h0, all_muted}, 32'h1);
      check("final_pending", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
